// File: rtl/mod_counter_pkg.sv
// Shared constants and parameter-range helper for the mod_counter family.
package mod_counter_pkg;

  localparam logic DIR_DOWN = 1'b0;
  localparam logic DIR_UP   = 1'b1;

  localparam int MODE_WRAP     = 32'sd0;
  localparam int MODE_SATURATE = 32'sd1;

  function automatic bit max_value_ok(input int width, input longint unsigned max_value);
    longint unsigned limit;
    limit = (64'd1 << width) - 64'd1;
    return (max_value >= 64'd1) && (max_value <= limit);
  endfunction

endpackage

// File: rtl/mod_counter_prescaler.sv
// Enable prescaler for mod_counter: one tick per PRESCALE enabled cycles.
module count_prescaler #(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST_C = PW'(PRESCALE - 1);
  localparam logic [PW-1:0] ZERO_C = {PW{1'b0}};
  localparam logic [PW-1:0] ONE_C  = PW'(1'b1);

  logic [PW-1:0] phase_r;

  assign tick = enable && (phase_r == LAST_C);

  // Phase advances only on enabled cycles and restarts after the terminal phase.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      phase_r <= ZERO_C;
    end else if (clear) begin
      phase_r <= ZERO_C;
    end else if (enable) begin
      if (phase_r == LAST_C) begin
        phase_r <= ZERO_C;
      end else begin
        phase_r <= phase_r + ONE_C;
      end
    end else begin
      phase_r <= phase_r;
    end
  end

endmodule

// File: rtl/mod_counter.sv
// Parametrised modulo up/down counter with wrap/saturate mode and limit flags.
// Optional enable prescaler is built when COUNTER_PRESCALE_EN is defined.
module mod_counter
  import mod_counter_pkg::*;
#(
  parameter int              WIDTH     = 8,
  parameter longint unsigned MAX_VALUE = (64'd1 << WIDTH) - 64'd1,
  parameter int              SATURATE  = 0,
  parameter int              PRESCALE  = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             up_down,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic             max_reached,
  output logic             min_reached,
  output logic             wrap_pulse,
  output logic             overflow_sticky
);

  if (!max_value_ok(WIDTH, MAX_VALUE) || (WIDTH < 2) || (WIDTH > 32) || (PRESCALE < 1) ||
      ((SATURATE != MODE_WRAP) && (SATURATE != MODE_SATURATE))) begin : g_param_err
    $error("mod_counter: illegal WIDTH/MAX_VALUE/SATURATE/PRESCALE combination");
  end

  localparam logic [WIDTH-1:0] MAX_C  = WIDTH'(MAX_VALUE);
  localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_C  = WIDTH'(1'b1);
  localparam bit               SAT_C  = (SATURATE == MODE_SATURATE);

  logic [WIDTH-1:0] count_r, count_n_s;
  logic             wrap_r, wrap_n_s;
  logic             sticky_r, sticky_n_s;
  logic             tick_s;

`ifdef COUNTER_PRESCALE_EN
  count_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (enable),
    .clear   (clear | load),
    .tick    (tick_s)
  );
`else
  assign tick_s = enable;
`endif

  // Next-state: clear > load > step; a step past either limit is a limit event.
  always_comb begin
    count_n_s  = count_r;
    wrap_n_s   = 1'b0;
    sticky_n_s = sticky_r;
    if (clear) begin
      count_n_s  = ZERO_C;
      sticky_n_s = 1'b0;
    end else if (load) begin
      count_n_s = (load_value > MAX_C) ? MAX_C : load_value;
    end else if (tick_s) begin
      case (up_down)
        DIR_UP: begin
          if (count_r == MAX_C) begin
            wrap_n_s   = 1'b1;
            sticky_n_s = 1'b1;
            count_n_s  = SAT_C ? MAX_C : ZERO_C;
          end else begin
            count_n_s = count_r + ONE_C;
          end
        end
        DIR_DOWN: begin
          if (count_r == ZERO_C) begin
            wrap_n_s   = 1'b1;
            sticky_n_s = 1'b1;
            count_n_s  = SAT_C ? ZERO_C : MAX_C;
          end else begin
            count_n_s = count_r - ONE_C;
          end
        end
        default: count_n_s = count_r;
      endcase
    end else begin
      count_n_s = count_r;
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_r  <= ZERO_C;
      wrap_r   <= 1'b0;
      sticky_r <= 1'b0;
    end else begin
      count_r  <= count_n_s;
      wrap_r   <= wrap_n_s;
      sticky_r <= sticky_n_s;
    end
  end

  assign count           = count_r;
  assign wrap_pulse      = wrap_r;
  assign overflow_sticky = sticky_r;
  assign max_reached     = (count_r == MAX_C);
  assign min_reached     = (count_r == ZERO_C);

endmodule

// File: tb/tb_mod_counter.sv
// Self-checking bench for mod_counter: vector table, directed corner sequences
// and a randomized run against an arithmetic reference model.
module tb_mod_counter;

  localparam int M = 199;

  logic       clk = 1'b0;
  logic       reset_n, enable, up_down, clear, load;
  logic [7:0] load_value;

  logic [7:0] count_w, count_s;
  logic       max_w, min_w, wp_w, st_w;
  logic       max_s, min_s, wp_s, st_s;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mod_counter #(.WIDTH(8), .MAX_VALUE(199), .SATURATE(0), .PRESCALE(1)) dut_w (
    .clk(clk), .reset_n(reset_n), .enable(enable), .up_down(up_down),
    .clear(clear), .load(load), .load_value(load_value), .count(count_w),
    .max_reached(max_w), .min_reached(min_w), .wrap_pulse(wp_w), .overflow_sticky(st_w)
  );

  mod_counter #(.WIDTH(8), .MAX_VALUE(199), .SATURATE(1), .PRESCALE(1)) dut_s (
    .clk(clk), .reset_n(reset_n), .enable(enable), .up_down(up_down),
    .clear(clear), .load(load), .load_value(load_value), .count(count_s),
    .max_reached(max_s), .min_reached(min_s), .wrap_pulse(wp_s), .overflow_sticky(st_s)
  );

`ifdef COUNTER_PRESCALE_EN
  logic [7:0] count_p;
  logic       max_p, min_p, wp_p, st_p;
  mod_counter #(.WIDTH(8), .MAX_VALUE(199), .SATURATE(0), .PRESCALE(4)) dut_p (
    .clk(clk), .reset_n(reset_n), .enable(enable), .up_down(up_down),
    .clear(clear), .load(load), .load_value(load_value), .count(count_p),
    .max_reached(max_p), .min_reached(min_p), .wrap_pulse(wp_p), .overflow_sticky(st_p)
  );
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rn, input logic en, input logic ud,
                       input logic clr, input logic ld, input logic [7:0] lv);
    reset_n = rn; enable = en; up_down = ud; clear = clr; load = ld; load_value = lv;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input int cw, input logic ww, input logic sw,
                           input int cs, input logic ws, input logic ss);
    chk({tag, "/w.count"}, 32'(count_w), 32'(cw));
    chk({tag, "/w.wrap"}, 32'(wp_w), 32'(ww));
    chk({tag, "/w.sticky"}, 32'(st_w), 32'(sw));
    chk({tag, "/w.max"}, 32'(max_w), 32'(cw == M));
    chk({tag, "/w.min"}, 32'(min_w), 32'(cw == 0));
    chk({tag, "/s.count"}, 32'(count_s), 32'(cs));
    chk({tag, "/s.wrap"}, 32'(wp_s), 32'(ws));
    chk({tag, "/s.sticky"}, 32'(st_s), 32'(ss));
    chk({tag, "/s.max"}, 32'(max_s), 32'(cs == M));
    chk({tag, "/s.min"}, 32'(min_s), 32'(cs == 0));
  endtask

  typedef struct {
    logic       rn, en, ud, clr, ld;
    logic [7:0] lv;
    int         cw; logic ww, sw;
    int         cs; logic ws, ss;
  } vec_t;

  // Reference model: integer arithmetic on [0, M], wrap via modulo, saturate via clamp.
  int mc[2];
  bit mwp[2], mst[2];

  task automatic model_step(input logic rn, input logic en, input logic ud,
                            input logic clr, input logic ld, input logic [7:0] lv);
    for (int k = 0; k < 2; k++) begin
      int nxt;
      if (!rn || clr) begin
        mc[k] = 0; mwp[k] = 1'b0; mst[k] = 1'b0;
      end else if (ld) begin
        mc[k] = (int'(lv) > M) ? M : int'(lv); mwp[k] = 1'b0;
      end else if (en) begin
        nxt = mc[k] + (ud ? 1 : -1);
        mwp[k] = (nxt < 0) || (nxt > M);
        if (mwp[k]) mst[k] = 1'b1;
        if (k == 1) mc[k] = (nxt < 0) ? 0 : ((nxt > M) ? M : nxt);
        else        mc[k] = (nxt + M + 1) % (M + 1);
      end else begin
        mwp[k] = 1'b0;
      end
    end
  endtask

  initial begin
    vec_t tbl[17];
    int   pulses;

    tbl[0]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,8'd0,    0,1'b0,1'b0,   0,1'b0,1'b0};
    tbl[1]  = '{1'b1,1'b1,1'b1,1'b0,1'b0,8'd0,    1,1'b0,1'b0,   1,1'b0,1'b0};
    tbl[2]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,8'd0,    0,1'b0,1'b0,   0,1'b0,1'b0};
    tbl[3]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,8'd0,  199,1'b1,1'b1,   0,1'b1,1'b1};
    tbl[4]  = '{1'b1,1'b0,1'b1,1'b0,1'b0,8'd0,  199,1'b0,1'b1,   0,1'b0,1'b1};
    tbl[5]  = '{1'b1,1'b0,1'b0,1'b0,1'b1,8'd250,199,1'b0,1'b1, 199,1'b0,1'b1};
    tbl[6]  = '{1'b1,1'b1,1'b1,1'b0,1'b0,8'd0,    0,1'b1,1'b1, 199,1'b1,1'b1};
    tbl[7]  = '{1'b1,1'b1,1'b1,1'b0,1'b0,8'd0,    1,1'b0,1'b1, 199,1'b1,1'b1};
    tbl[8]  = '{1'b1,1'b1,1'b1,1'b0,1'b1,8'd57,  57,1'b0,1'b1,  57,1'b0,1'b1};
    tbl[9]  = '{1'b1,1'b1,1'b0,1'b1,1'b0,8'd0,    0,1'b0,1'b0,   0,1'b0,1'b0};
    tbl[10] = '{1'b1,1'b0,1'b0,1'b0,1'b1,8'd57,  57,1'b0,1'b0,  57,1'b0,1'b0};
    tbl[11] = '{1'b0,1'b1,1'b1,1'b0,1'b1,8'd100,  0,1'b0,1'b0,   0,1'b0,1'b0};
    tbl[12] = '{1'b1,1'b1,1'b1,1'b0,1'b0,8'd0,    1,1'b0,1'b0,   1,1'b0,1'b0};
    tbl[13] = '{1'b1,1'b1,1'b1,1'b1,1'b1,8'd77,   0,1'b0,1'b0,   0,1'b0,1'b0};
    tbl[14] = '{1'b1,1'b0,1'b0,1'b0,1'b1,8'd198,198,1'b0,1'b0, 198,1'b0,1'b0};
    tbl[15] = '{1'b1,1'b1,1'b1,1'b0,1'b0,8'd0,  199,1'b0,1'b0, 199,1'b0,1'b0};
    tbl[16] = '{1'b1,1'b1,1'b1,1'b0,1'b1,8'd5,    5,1'b0,1'b0,   5,1'b0,1'b0};

    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].rn, tbl[i].en, tbl[i].ud, tbl[i].clr, tbl[i].ld, tbl[i].lv);
      check_all($sformatf("vec%0d", i), tbl[i].cw, tbl[i].ww, tbl[i].sw,
                tbl[i].cs, tbl[i].ws, tbl[i].ss);
    end

    // Full wrap period counting up.
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    pulses = 0;
    for (int i = 1; i <= 200; i++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
      pulses += int'(wp_w);
      if (i == 199) begin
        chk("period/count199", 32'(count_w), 32'd199);
        chk("period/max199", 32'(max_w), 32'd1);
      end
    end
    chk("period/count_wrap", 32'(count_w), 32'd0);
    chk("period/pulse", 32'(wp_w), 32'd1);
    chk("period/sticky", 32'(st_w), 32'd1);
    chk("period/pulses", 32'(pulses), 32'd1);
    chk("period/sat_hold", 32'(count_s), 32'd199);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
    chk("period/pulse_drop", 32'(wp_w), 32'd0);
    chk("period/count_next", 32'(count_w), 32'd1);

    // Down from reset: wrap to MAX then decrement.
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    check_all("down1", 199, 1'b1, 1'b1, 0, 1'b1, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    check_all("down2", 198, 1'b0, 1'b1, 0, 1'b1, 1'b1);

    // Saturate at top for 5 steps, then down 3.
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd199);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
      chk($sformatf("sat_up%0d/count", i), 32'(count_s), 32'd199);
      chk($sformatf("sat_up%0d/wrap", i), 32'(wp_s), 32'd1);
    end
    chk("sat/sticky", 32'(st_s), 32'd1);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    chk("sat/down3", 32'(count_s), 32'd196);
    chk("sat/down_wrap", 32'(wp_s), 32'd0);

    // Reset mid-count overrides enable/load; sticky survives load but not reset.
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd57);
    check_all("at57", 57, 1'b0, 1'b1, 57, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'd99);
    check_all("rst57", 0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
    check_all("resume", 1, 1'b0, 1'b0, 1, 1'b0, 1'b0);

`ifdef COUNTER_PRESCALE_EN
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
    chk("pre/after5", 32'(count_p), 32'd1);
    for (int i = 0; i < 2; i++) drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    for (int i = 0; i < 7; i++) drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
    chk("pre/after12", 32'(count_p), 32'd3);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    for (int i = 0; i < 2; i++) drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'd10);
    chk("pre/load", 32'(count_p), 32'd10);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
    chk("pre/phase3", 32'(count_p), 32'd10);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
    chk("pre/phase4", 32'(count_p), 32'd11);
`endif

    // Randomized run against the reference model.
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    model_step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    for (int i = 0; i < 1500; i++) begin
      logic rn, en, ud, clr, ld;
      logic [7:0] lv;
      rn  = ($urandom_range(0, 99) != 0);
      en  = ($urandom_range(0, 3) != 0);
      ud  = ($urandom_range(0, 9) < 6);
      clr = ($urandom_range(0, 59) == 0);
      ld  = ($urandom_range(0, 24) == 0);
      lv  = 8'($urandom_range(0, 255));
      drive(rn, en, ud, clr, ld, lv);
      model_step(rn, en, ud, clr, ld, lv);
      check_all($sformatf("rnd%0d", i), mc[0], mwp[0], mst[0], mc[1], mwp[1], mst[1]);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mod_counter.md
# mod_counter

Parametrised modulo up/down counter; generalises the free-running 8-bit enable counter to configurable width and modulus, with direction control, synchronous load/clear, wrap-or-saturate mode and event flags. Sits alongside datapath control logic as a general event/sequence counter whose terminal flags feed downstream combinational decode.

## Interface
- WIDTH, 8, counter width in bits (2..32)
- MAX_VALUE, 2**WIDTH-1, highest count value (modulus minus one); must be ≥1 and ≤ 2**WIDTH-1
- SATURATE, 0, 0 = wrap at limits, 1 = hold at limits
- PRESCALE, 4, enabled cycles per count step; used only when COUNTER_PRESCALE_EN is defined (≥1)

- clk  input  1  clock; all state updates on rising edge
- reset_n  input  1  synchronous, active-low reset
- enable  input  1  count request for this cycle
- up_down  input  1  1 = count up, 0 = count down
- clear  input  1  synchronous clear to 0
- load  input  1  synchronous load of load_value
- load_value  input  WIDTH  value for load
- count  output  WIDTH  current count (registered)
- max_reached  output  1  combinational: count == MAX_VALUE
- min_reached  output  1  combinational: count == 0
- wrap_pulse  output  1  registered, one cycle high after a limit event
- overflow_sticky  output  1  registered, set on any limit event, held until clear or reset

## Operation
- Per-cycle priority: reset_n low > clear > load > step.
- Reset (reset_n=0 at edge): count=0, wrap_pulse=0, overflow_sticky=0, prescaler=0.
- clear: count=0, overflow_sticky=0, wrap_pulse=0, prescaler=0.
- load: count=min(load_value, MAX_VALUE); wrap_pulse=0; overflow_sticky unchanged; prescaler=0.
- step: occurs when tick=1 (tick=enable without prescaler).
  - up, count<MAX_VALUE: count+1. Up, count==MAX_VALUE: limit event → count=0 (SATURATE=0) or hold MAX_VALUE (SATURATE=1).
  - down, count>0: count-1. Down, count==0: limit event → count=MAX_VALUE (SATURATE=0) or hold 0 (SATURATE=1).
- Limit event: wrap_pulse=1 for the following cycle only; overflow_sticky=1.
- No step, clear or load: count holds, wrap_pulse=0.
- Arithmetic in WIDTH bits; never produces values above MAX_VALUE.
- enable with clear or load in same cycle: step discarded.

## Timing
- count, wrap_pulse, overflow_sticky change one cycle after the qualifying edge; zero additional latency.
- max_reached/min_reached follow count combinationally in the same cycle.
- up_down sampled only in cycles where tick=1; may change every cycle.
- Reset asserted mid-count: state forced to reset values at that edge regardless of other inputs.
- Continuous enable up, wrap mode: count period = MAX_VALUE+1 steps; wrap_pulse one cycle per period.

## Configuration
- COUNTER_PRESCALE_EN defined: internal prescale counter counts enabled cycles 0..PRESCALE-1; tick=1 on the enabled cycle where prescaler==PRESCALE-1, prescaler then returns to 0. Prescaler holds when enable=0; reset by reset_n, clear, load. PRESCALE=1 equals tick=enable.
- Not defined: no prescaler logic; tick=enable; PRESCALE ignored.

## Structure
- Shared package: direction constants (DIR_DOWN=0, DIR_UP=1), mode constants (MODE_WRAP=0, MODE_SATURATE=1), parameter-check helper for MAX_VALUE range.
- Sub-module: count_prescaler (enable, clear → tick), instantiated only under COUNTER_PRESCALE_EN.
- Elaboration-time error on MAX_VALUE=0, MAX_VALUE>2**WIDTH-1 or PRESCALE=0.

## Test plan
- WIDTH=8, MAX_VALUE=199, wrap: reset, enable up 200 cycles → count 199 with max_reached=1 at cycle 199, count 0 next, wrap_pulse high exactly one cycle, overflow_sticky=1.
- Same config, down from reset: first step → count 199, wrap_pulse=1, min_reached=0; second → 198.
- SATURATE=1, load 199, enable up 5 cycles → count stays 199, overflow_sticky=1, wrap_pulse high each limit cycle; down 3 → 196.
- load_value=250 with MAX_VALUE=199 → count 199; load and clear asserted together with enable → count 0, overflow_sticky 0.
- reset_n low for one cycle at count 57 with enable/load active → count 0, all flags 0 next cycle; counting resumes from 0.
- COUNTER_PRESCALE_EN, PRESCALE=4: enable 12 cycles with 2-cycle enable gap after cycle 5 → count 3; load mid-prescale restarts prescale phase.
